spi_wb_arbiter: RTL and testbench
=================================

// Module: spi_wb_arbiter
// PURPOSE
//  Two-master Wishbone arbiter that shares the single spixpress SPI-flash slave port
//  (wb + cfg strobes) between requester A (e.g. instruction fetch) and requester B (data bus).
//  Round-robin grant; the owner keeps the bus while its cyc is high, with bounded-burst
//  preemption so neither master starves. Sits directly in front of spixpress; no data buffering.
// PARAMETERS
//  MAX_BURST  16  accepted strobes an owner may issue while the other master waits; >=1
//  CNT_W      4   width of the outstanding-transaction counter; saturates at 2**CNT_W-1
// PORTS
//  i_clk         in   1   clock
//  i_reset       in   1   async reset, active high
//  i_a_cyc/i_b_cyc          in  1   master bus cycle (request = cyc)
//  i_a_stb/i_b_stb          in  1   memory strobe
//  i_a_cfg_stb/i_b_cfg_stb  in  1   config-port strobe
//  i_a_we/i_b_we            in  1   write enable
//  i_a_addr/i_b_addr        in  22  word address
//  i_a_data/i_b_data        in  32  write data
//  o_a_stall/o_b_stall      out 1   stall to master
//  o_a_ack/o_b_ack          out 1   ack to master
//  o_a_data/o_b_data        out 32  read data (both = i_spi_data)
//  o_spi_cyc,o_spi_stb,o_spi_cfg_stb,o_spi_we  out 1   to spixpress
//  o_spi_addr    out  22  to spixpress
//  o_spi_data    out  32  to spixpress
//  i_spi_stall,i_spi_ack  in 1  from spixpress
//  i_spi_data    in   32  from spixpress
// BEHAVIOUR
//  Reset: state=IDLE, last_grant=B (A wins first tie), burst_cnt=0, out_cnt=0;
//   o_spi_cyc/stb/cfg_stb=0, o_*_ack=0, o_*_stall=1.
//  States: IDLE, OWN_A, OWN_B, DRAIN (owner blocked pending handover). Grant is registered.
//  IDLE: only A cyc -> OWN_A; only B -> OWN_B; both -> master != last_grant. Requester
//   stalled in the request cycle (1-cycle grant latency); downstream idle.
//  OWN_X: o_spi_cyc=x_cyc; stb/cfg_stb/we/addr/data muxed from X; o_x_stall=i_spi_stall;
//   other master stall=1, ack=0. accept = (stb|cfg_stb)&!i_spi_stall.
//   burst_cnt += accept (saturating); out_cnt += accept - i_spi_ack.
//   !x_cyc -> IDLE same cycle: o_spi_cyc drops combinationally (abort), out_cnt:=0,
//   burst_cnt:=0, last_grant:=X.
//   other cyc && burst_cnt>=MAX_BURST -> DRAIN.
//  DRAIN: o_spi_cyc=x_cyc, o_spi_stb=o_spi_cfg_stb=0, o_x_stall=1; acks still go to X.
//   !x_cyc -> IDLE (abort as above). out_cnt==0 (incl. ack this cycle) -> OWN_other next
//   cycle, burst_cnt:=0, last_grant:=X; X stays stalled until re-granted via normal request.
//   If the other master drops cyc while in DRAIN -> back to OWN_X, burst_cnt kept.
//  Acks: i_spi_ack routed to owner only; ack arriving in IDLE or same cycle as abort discarded.
//   out_cnt never underflows (ack at 0 ignored).
//  Simultaneous: owner cyc drop + other request same cycle -> IDLE then OWN_other (no skip).
//  Reset mid-transfer: all outputs to reset values immediately (async), no ack emitted.
//  Reset mid-transfer: pending slave ack after reset is discarded.
// TESTING
//  A alone: cyc+stb read addr 0x000010 -> stall 1 cycle, then o_spi_stb with addr 0x10; ack to A only.
//  A,B cyc same cycle after reset -> A granted; after A drops cyc, B granted next cycle.
//  MAX_BURST=4, A streams 10 reads while B waits -> after 4th accept A stalled; B owns bus
//   after 4th ack; B never stalled >4 slave acks + 2 cycles.
//  A drops cyc with 1 outstanding -> o_spi_cyc low same cycle; late slave ack not seen by A or B.
//  B cfg_stb write 0x000001FF while A idle -> o_spi_cfg_stb=1, o_spi_we=1, data=0x1FF.
//  i_reset asserted mid-burst -> o_spi_cyc=0 and both stalls=1 without a clock edge.

Source files
------------

// File: rtl/spi_wb_arbiter.sv
// Round-robin two-master Wishbone arbiter in front of the spixpress flash port (wb + cfg strobes).
// Grant is registered (1 cycle from idle request); no buffering, owner sees slave stall, the waiting master sees stall=1.
module spi_wb_arbiter #(
  parameter int MAX_BURST = 16,
  parameter int CNT_W     = 4
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_a_cyc,
  input  logic        i_a_stb,
  input  logic        i_a_cfg_stb,
  input  logic        i_a_we,
  input  logic [21:0] i_a_addr,
  input  logic [31:0] i_a_data,
  output logic        o_a_stall,
  output logic        o_a_ack,
  output logic [31:0] o_a_data,
  input  logic        i_b_cyc,
  input  logic        i_b_stb,
  input  logic        i_b_cfg_stb,
  input  logic        i_b_we,
  input  logic [21:0] i_b_addr,
  input  logic [31:0] i_b_data,
  output logic        o_b_stall,
  output logic        o_b_ack,
  output logic [31:0] o_b_data,
  output logic        o_spi_cyc,
  output logic        o_spi_stb,
  output logic        o_spi_cfg_stb,
  output logic        o_spi_we,
  output logic [21:0] o_spi_addr,
  output logic [31:0] o_spi_data,
  input  logic        i_spi_stall,
  input  logic        i_spi_ack,
  input  logic [31:0] i_spi_data
);

  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [BW-1:0] MAX_B = BW'(MAX_BURST);

  typedef enum logic [1:0] {S_IDLE, S_OWN_A, S_OWN_B, S_DRAIN} state_t;

  state_t           state;
  logic             owner_b;
  logic             last_b;
  logic [BW-1:0]    burst_cnt;
  logic [CNT_W-1:0] out_cnt;

  logic             own, active, live;
  logic             x_cyc, y_cyc, x_stb, x_cfg_stb;
  logic             accept, ack_dec;
  logic [CNT_W:0]   out_wide;
  logic [CNT_W-1:0] out_nxt;
  logic [BW-1:0]    burst_nxt;

  assign own    = (state == S_OWN_A) || (state == S_OWN_B);
  assign active = own || (state == S_DRAIN);

  assign x_cyc     = owner_b ? i_b_cyc     : i_a_cyc;
  assign y_cyc     = owner_b ? i_a_cyc     : i_b_cyc;
  assign x_stb     = owner_b ? i_b_stb     : i_a_stb;
  assign x_cfg_stb = owner_b ? i_b_cfg_stb : i_a_cfg_stb;

  // Dropping owner cyc kills the downstream cycle in the same clock (abort).
  assign live    = active && x_cyc;
  assign accept  = own && x_cyc && (x_stb || x_cfg_stb) && !i_spi_stall;
  assign ack_dec = i_spi_ack && (out_cnt != '0);

  assign out_wide  = {1'b0, out_cnt} + (CNT_W+1)'(accept) - (CNT_W+1)'(ack_dec);
  assign out_nxt   = out_wide[CNT_W] ? {CNT_W{1'b1}} : out_wide[CNT_W-1:0];
  assign burst_nxt = (burst_cnt == MAX_B) ? burst_cnt : burst_cnt + BW'(accept);

  assign o_spi_cyc     = live;
  assign o_spi_stb     = own && x_cyc && x_stb;
  assign o_spi_cfg_stb = own && x_cyc && x_cfg_stb;
  assign o_spi_we      = owner_b ? i_b_we   : i_a_we;
  assign o_spi_addr    = owner_b ? i_b_addr : i_a_addr;
  assign o_spi_data    = owner_b ? i_b_data : i_a_data;

  assign o_a_stall = (own && !owner_b) ? i_spi_stall : 1'b1;
  assign o_b_stall = (own &&  owner_b) ? i_spi_stall : 1'b1;
  assign o_a_ack   = live && !owner_b && i_spi_ack;
  assign o_b_ack   = live &&  owner_b && i_spi_ack;
  assign o_a_data  = i_spi_data;
  assign o_b_data  = i_spi_data;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state     <= S_IDLE;
      owner_b   <= 1'b0;
      last_b    <= 1'b1;
      burst_cnt <= '0;
      out_cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          burst_cnt <= '0;
          out_cnt   <= '0;
          if (i_a_cyc && (!i_b_cyc || last_b)) begin
            state   <= S_OWN_A;
            owner_b <= 1'b0;
          end else if (i_b_cyc) begin
            state   <= S_OWN_B;
            owner_b <= 1'b1;
          end
        end
        S_OWN_A, S_OWN_B: begin
          if (!x_cyc) begin
            state     <= S_IDLE;
            last_b    <= owner_b;
            burst_cnt <= '0;
            out_cnt   <= '0;
          end else begin
            burst_cnt <= burst_nxt;
            out_cnt   <= out_nxt;
            // Check the post-accept count so the owner is stalled right after its last allowed strobe.
            if (y_cyc && (burst_nxt >= MAX_B))
              state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (!x_cyc) begin
            state     <= S_IDLE;
            last_b    <= owner_b;
            burst_cnt <= '0;
            out_cnt   <= '0;
          end else if (!y_cyc) begin
            state   <= owner_b ? S_OWN_B : S_OWN_A;
            out_cnt <= out_nxt;
          end else if (out_nxt == '0) begin
            state     <= owner_b ? S_OWN_A : S_OWN_B;
            owner_b   <= !owner_b;
            last_b    <= owner_b;
            burst_cnt <= '0;
            out_cnt   <= '0;
          end else begin
            out_cnt <= out_nxt;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_wb_arbiter.sv
// Bench for spi_wb_arbiter: directed scenarios then random traffic against a cycle-level reference model.
module tb_spi_wb_arbiter;
  localparam int MB = 4;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_a_cyc, i_a_stb, i_a_cfg_stb, i_a_we;
  logic [21:0] i_a_addr;
  logic [31:0] i_a_data;
  logic        o_a_stall, o_a_ack;
  logic [31:0] o_a_data;
  logic        i_b_cyc, i_b_stb, i_b_cfg_stb, i_b_we;
  logic [21:0] i_b_addr;
  logic [31:0] i_b_data;
  logic        o_b_stall, o_b_ack;
  logic [31:0] o_b_data;
  logic        o_spi_cyc, o_spi_stb, o_spi_cfg_stb, o_spi_we;
  logic [21:0] o_spi_addr;
  logic [31:0] o_spi_data;
  logic        i_spi_stall, i_spi_ack;
  logic [31:0] i_spi_data;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: owner 0=none 1=A 2=B, hold=owner blocked waiting to hand over.
  int m_owner, m_last, m_burst, m_out;
  bit m_hold;

  spi_wb_arbiter #(.MAX_BURST(MB), .CNT_W(4)) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_a_cyc(i_a_cyc), .i_a_stb(i_a_stb), .i_a_cfg_stb(i_a_cfg_stb), .i_a_we(i_a_we),
    .i_a_addr(i_a_addr), .i_a_data(i_a_data),
    .o_a_stall(o_a_stall), .o_a_ack(o_a_ack), .o_a_data(o_a_data),
    .i_b_cyc(i_b_cyc), .i_b_stb(i_b_stb), .i_b_cfg_stb(i_b_cfg_stb), .i_b_we(i_b_we),
    .i_b_addr(i_b_addr), .i_b_data(i_b_data),
    .o_b_stall(o_b_stall), .o_b_ack(o_b_ack), .o_b_data(o_b_data),
    .o_spi_cyc(o_spi_cyc), .o_spi_stb(o_spi_stb), .o_spi_cfg_stb(o_spi_cfg_stb), .o_spi_we(o_spi_we),
    .o_spi_addr(o_spi_addr), .o_spi_data(o_spi_data),
    .i_spi_stall(i_spi_stall), .i_spi_ack(i_spi_ack), .i_spi_data(i_spi_data)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = 0; m_last = 2; m_burst = 0; m_out = 0; m_hold = 0;
  endtask

  task automatic check_model();
    bit oc, live, ostb, ocfg, owe;
    logic [21:0] oaddr;
    logic [31:0] odata;
    oc    = (m_owner == 1) ? i_a_cyc : (m_owner == 2) ? i_b_cyc : 1'b0;
    ostb  = (m_owner == 2) ? i_b_stb : i_a_stb;
    ocfg  = (m_owner == 2) ? i_b_cfg_stb : i_a_cfg_stb;
    owe   = (m_owner == 2) ? i_b_we : i_a_we;
    oaddr = (m_owner == 2) ? i_b_addr : i_a_addr;
    odata = (m_owner == 2) ? i_b_data : i_a_data;
    live  = (m_owner != 0) && oc;
    chk("spi_cyc", 32'(o_spi_cyc), 32'(live));
    chk("spi_stb", 32'(o_spi_stb), 32'(live && !m_hold && ostb));
    chk("spi_cfg_stb", 32'(o_spi_cfg_stb), 32'(live && !m_hold && ocfg));
    chk("a_stall", 32'(o_a_stall), 32'((m_owner == 1 && !m_hold) ? i_spi_stall : 1'b1));
    chk("b_stall", 32'(o_b_stall), 32'((m_owner == 2 && !m_hold) ? i_spi_stall : 1'b1));
    chk("a_ack", 32'(o_a_ack), 32'(live && m_owner == 1 && i_spi_ack));
    chk("b_ack", 32'(o_b_ack), 32'(live && m_owner == 2 && i_spi_ack));
    chk("a_rdata", o_a_data, i_spi_data);
    chk("b_rdata", o_b_data, i_spi_data);
    if (live) begin
      chk("spi_we", 32'(o_spi_we), 32'(owe));
      chk("spi_addr", 32'(o_spi_addr), 32'(oaddr));
      chk("spi_wdata", o_spi_data, odata);
    end
  endtask

  task automatic model_step();
    bit oc, other, acc;
    if (m_owner == 0) begin
      m_burst = 0; m_out = 0; m_hold = 0;
      if (i_a_cyc && (!i_b_cyc || m_last == 2)) m_owner = 1;
      else if (i_b_cyc) m_owner = 2;
    end else begin
      oc    = (m_owner == 1) ? i_a_cyc : i_b_cyc;
      other = (m_owner == 1) ? i_b_cyc : i_a_cyc;
      if (!oc) begin
        m_last = m_owner; m_owner = 0; m_burst = 0; m_out = 0; m_hold = 0;
      end else begin
        acc = !m_hold && !i_spi_stall &&
              ((m_owner == 1) ? (i_a_stb || i_a_cfg_stb) : (i_b_stb || i_b_cfg_stb));
        m_burst += int'(acc);
        if (i_spi_ack && m_out > 0) m_out--;
        m_out += int'(acc);
        if (m_out > 15) m_out = 15;
        if (!m_hold) begin
          if (other && m_burst >= MB) m_hold = 1;
        end else if (!other) begin
          m_hold = 0;
        end else if (m_out == 0) begin
          m_last = m_owner; m_owner = 3 - m_owner; m_burst = 0; m_hold = 0;
        end
      end
    end
  endtask

  task automatic settle();
    #2;
    check_model();
  endtask

  task automatic tick();
    @(posedge i_clk);
    model_step();
    #1;
  endtask

  task automatic idle_inputs();
    i_a_cyc = 0; i_a_stb = 0; i_a_cfg_stb = 0; i_a_we = 0; i_a_addr = '0; i_a_data = '0;
    i_b_cyc = 0; i_b_stb = 0; i_b_cfg_stb = 0; i_b_we = 0; i_b_addr = '0; i_b_data = '0;
    i_spi_stall = 0; i_spi_ack = 0; i_spi_data = 32'hCAFE_0000;
  endtask

  task automatic do_reset();
    i_reset = 1'b1;
    #1;
    model_reset();
    chk("rst_spi_cyc", 32'(o_spi_cyc), 32'd0);
    chk("rst_spi_stb", 32'(o_spi_stb), 32'd0);
    chk("rst_a_stall", 32'(o_a_stall), 32'd1);
    chk("rst_b_stall", 32'(o_b_stall), 32'd1);
    chk("rst_a_ack", 32'(o_a_ack), 32'd0);
    @(posedge i_clk);
    #1;
    i_reset = 1'b0;
  endtask

  initial begin
    int acc_a, pend;
    bit got_b;
    int r;
    idle_inputs();
    do_reset();

    // A alone reads 0x10: one cycle of grant latency, then strobe, ack only to A.
    i_a_cyc = 1; i_a_stb = 1; i_a_addr = 22'h000010;
    settle();
    chk("t_read_req_stall", 32'(o_a_stall), 32'd1);
    chk("t_read_req_stb", 32'(o_spi_stb), 32'd0);
    tick();
    settle();
    chk("t_read_stb", 32'(o_spi_stb), 32'd1);
    chk("t_read_addr", 32'(o_spi_addr), 32'h10);
    chk("t_read_stall", 32'(o_a_stall), 32'd0);
    tick();
    i_a_stb = 0; i_spi_ack = 1; i_spi_data = 32'h1234_5678;
    settle();
    chk("t_read_ack_a", 32'(o_a_ack), 32'd1);
    chk("t_read_ack_b", 32'(o_b_ack), 32'd0);
    chk("t_read_data", o_a_data, 32'h1234_5678);
    tick();
    idle_inputs();
    settle(); tick();

    // Simultaneous request after reset: A first, B after A leaves.
    do_reset();
    i_a_cyc = 1; i_b_cyc = 1;
    settle(); tick();
    settle();
    chk("t_tie_a_granted", 32'(o_a_stall), 32'd0);
    chk("t_tie_b_waits", 32'(o_b_stall), 32'd1);
    tick();
    i_a_cyc = 0;
    settle();
    chk("t_tie_abort_cyc", 32'(o_spi_cyc), 32'd0);
    tick();
    settle(); tick();
    settle();
    chk("t_tie_b_granted", 32'(o_b_stall), 32'd0);
    tick();
    idle_inputs();
    settle(); tick();

    // Bounded burst: A streams with B waiting; handover once A's 4 accepts are acked.
    do_reset();
    i_a_cyc = 1; i_a_stb = 1; i_b_cyc = 1; i_b_stb = 1;
    acc_a = 0; pend = 0; got_b = 0;
    for (int n = 0; n < 40; n++) begin
      i_spi_ack = (n >= 6) && (pend > 0);
      settle();
      if (o_spi_stb && !o_a_stall) begin acc_a++; pend++; end
      if (i_spi_ack) pend--;
      if (!o_b_stall) begin got_b = 1; break; end
      tick();
    end
    chk("t_burst_a_accepts", 32'(acc_a), 32'(MB));
    chk("t_burst_b_granted", 32'(got_b), 32'd1);
    tick();
    idle_inputs();
    settle(); tick();

    // Abort with one outstanding; the late ack must vanish.
    do_reset();
    i_a_cyc = 1; i_a_stb = 1;
    settle(); tick();
    settle(); tick();
    i_a_cyc = 0; i_a_stb = 0;
    settle();
    chk("t_abort_cyc", 32'(o_spi_cyc), 32'd0);
    tick();
    i_spi_ack = 1;
    settle();
    chk("t_abort_late_ack_a", 32'(o_a_ack), 32'd0);
    chk("t_abort_late_ack_b", 32'(o_b_ack), 32'd0);
    tick();
    idle_inputs();

    // B config-port write while A idle.
    do_reset();
    i_b_cyc = 1; i_b_cfg_stb = 1; i_b_we = 1; i_b_data = 32'h0000_01FF;
    settle(); tick();
    settle();
    chk("t_cfg_stb", 32'(o_spi_cfg_stb), 32'd1);
    chk("t_cfg_mem_stb", 32'(o_spi_stb), 32'd0);
    chk("t_cfg_we", 32'(o_spi_we), 32'd1);
    chk("t_cfg_data", o_spi_data, 32'h0000_01FF);
    tick();
    idle_inputs();

    // Asynchronous reset in the middle of an A burst, with a slave ack pending.
    do_reset();
    i_a_cyc = 1; i_a_stb = 1;
    settle(); tick();
    settle();
    i_spi_ack = 1;
    i_reset = 1;
    #1;
    chk("t_arst_cyc", 32'(o_spi_cyc), 32'd0);
    chk("t_arst_a_stall", 32'(o_a_stall), 32'd1);
    chk("t_arst_b_stall", 32'(o_b_stall), 32'd1);
    chk("t_arst_a_ack", 32'(o_a_ack), 32'd0);
    model_reset();
    @(posedge i_clk);
    #1;
    i_reset = 0;
    settle();
    chk("t_arst_ack_discard", 32'(o_a_ack), 32'd0);
    tick();
    idle_inputs();
    settle(); tick();

    // Random traffic against the model.
    for (int n = 0; n < 4000; n++) begin
      if (i_a_cyc) begin
        if ($urandom_range(11) == 0) i_a_cyc = 0;
      end else if ($urandom_range(3) == 0) i_a_cyc = 1;
      if (i_b_cyc) begin
        if ($urandom_range(11) == 0) i_b_cyc = 0;
      end else if ($urandom_range(3) == 0) i_b_cyc = 1;
      r = int'($urandom_range(5));
      i_a_stb = i_a_cyc && (r < 3);
      i_a_cfg_stb = i_a_cyc && (r == 3);
      r = int'($urandom_range(5));
      i_b_stb = i_b_cyc && (r < 3);
      i_b_cfg_stb = i_b_cyc && (r == 3);
      i_a_we = 1'($urandom); i_b_we = 1'($urandom);
      i_a_addr = 22'($urandom); i_b_addr = 22'($urandom);
      i_a_data = $urandom; i_b_data = $urandom;
      i_spi_stall = ($urandom_range(3) == 0);
      i_spi_ack = ($urandom_range(2) == 0);
      i_spi_data = $urandom;
      if ($urandom_range(599) == 0) do_reset();
      settle();
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
